// File: rtl/msg_pkg.sv
// Shared types and constants for the message streamer: FSM state encoding,
// default geometry and the canned "Hello, World!" message used by loaders.
package msg_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam int MSG_HELLO_LEN = 13;
    localparam logic [8*MSG_HELLO_LEN-1:0] MSG_HELLO = "Hello, World!";

    // Symbol i of MSG_HELLO, counted from the first character ('H').
    function automatic logic [7:0] hello_char(input int i);
        return MSG_HELLO[8*(MSG_HELLO_LEN-1-i) +: 8];
    endfunction

endpackage

// File: rtl/msg_streamer_if.sv
// Loader/control inputs and the valid/ready symbol stream of msg_streamer.
// Handshake: a beat transfers on a rising clk edge where m_valid && m_ready;
// while m_valid is high and m_ready low, m_data and m_last are held stable.
interface msg_streamer_if
    import msg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W:0]   len;
    logic              repeat_en;
    logic              start;
    logic              abort;
    logic              m_ready;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              busy;
    logic              done;
    state_t            dbg_state;

    modport master (
        input  wr_en, wr_addr, wr_data, len, repeat_en, start, abort, m_ready,
        output m_valid, m_data, m_last, busy, done, dbg_state
    );

    modport slave (
        output wr_en, wr_addr, wr_data, len, repeat_en, start, abort, m_ready,
        input  m_valid, m_data, m_last, busy, done, dbg_state
    );

endinterface

// File: rtl/msg_buf.sv
// DEPTH x DATA_W symbol store: synchronous write, combinational read.
// The array is deliberately not reset; contents are undefined after power-up.
module msg_buf #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Writes beyond DEPTH (non power-of-two depths) are dropped.
    always_ff @(posedge clk) begin
        if (i_wr_en && (int'(i_wr_addr) < DEPTH)) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/msg_streamer.sv
// Streams buf[0..eff_len-1] as valid/ready beats, optionally looping until
// abort; pulses done one cycle after a completed single-shot pass.
module msg_streamer
    import msg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic           clk,
    input  logic           reset,
    msg_streamer_if.master bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   w_len_nxt;
    logic              r_rep;
    logic              w_rep_nxt;
    logic              r_done;
    logic              w_done_nxt;

    logic              w_streaming;
    logic              w_xfer;
    logic              w_is_last;
    logic              w_buf_wr_en;
    logic [ADDR_W:0]   w_len_eff;
    logic [DATA_W-1:0] w_rd_data;

    assign w_streaming = (r_state == STREAM);
    assign w_xfer      = w_streaming && bus.m_ready;
    assign w_is_last   = w_streaming && ({1'b0, r_idx} == (r_len - LEN_ONE));
    assign w_len_eff   = (bus.len > DEPTH_L) ? DEPTH_L : bus.len;
    // The buffer is frozen while a message is in flight.
    assign w_buf_wr_en = bus.wr_en && (r_state == IDLE);

    msg_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk       (clk),
        .i_wr_en   (w_buf_wr_en),
        .i_wr_addr (bus.wr_addr),
        .i_wr_data (bus.wr_data),
        .i_rd_addr (r_idx),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_len   <= '0;
            r_rep   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_len   <= w_len_nxt;
            r_rep   <= w_rep_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_len_nxt   = r_len;
        w_rep_nxt   = r_rep;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = STREAM;
                        w_idx_nxt   = '0;
                        w_len_nxt   = w_len_eff;
                        w_rep_nxt   = bus.repeat_en;
                    end
                end
            end
            STREAM: begin
                // Abort takes priority and suppresses done, even on the last beat.
                if (bus.abort) begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                end else if (w_xfer) begin
                    if (w_is_last) begin
                        w_idx_nxt = '0;
                        if (!r_rep) begin
                            w_state_nxt = IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_idx_nxt = r_idx + IDX_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign bus.m_valid   = w_streaming;
    assign bus.m_data    = w_streaming ? w_rd_data : '0;
    assign bus.m_last    = w_is_last;
    assign bus.busy      = w_streaming;
    assign bus.done      = r_done;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_msg_streamer.sv
// Directed + randomized bench for msg_streamer with a queue-based reference
// model of the expected symbol stream.
module tb_msg_streamer;
  import msg_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] mem_model [DEPTH];
  logic [DATA_W-1:0] exp_q [$];

  msg_streamer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  msg_streamer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.len = '0;
    bus.repeat_en = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.m_ready = 1'b0;
  endtask

  task automatic write_buf(input int a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    idle_inputs();
    bus.wr_en = 1'b1;
    bus.wr_addr = 4'(a);
    bus.wr_data = d;
    mem_model[a] = d;
  endtask

  // mode: 0 = always ready, 1 = ready pattern 1,0,0,1, 2 = random ready.
  // abort_beat > 0: abort is raised (with ready) on the cycle delivering that beat.
  // poke: hammer wr_en/start every streaming cycle; both must be ignored.
  task automatic stream_run(input int len_in, input bit rep, input int mode,
                            input int abort_beat, input bit poke);
    int eff;
    int total;
    int beats;
    int cyc;
    bit exp_done;
    bit rdy;
    logic [3:0] pat;
    pat = 4'b1001;
    eff = (len_in > DEPTH) ? DEPTH : len_in;
    if (eff == 0) total = 0;
    else if (rep) total = abort_beat;
    else if (abort_beat > 0 && abort_beat < eff) total = abort_beat;
    else total = eff;
    exp_done = (eff == 0) || (!rep && !(abort_beat > 0 && abort_beat <= eff));
    exp_q.delete();
    for (int k = 0; k < total; k++) exp_q.push_back(mem_model[k % eff]);

    @(negedge clk);
    idle_inputs();
    bus.start = 1'b1;
    bus.len = 5'(len_in);
    bus.repeat_en = rep;
    @(negedge clk);
    idle_inputs();
    beats = 0;
    cyc = 0;
    while (beats < total && cyc < 400) begin
      chk("valid_hi", 32'(bus.m_valid), 32'd1);
      chk("busy_hi", 32'(bus.busy), 32'd1);
      chk("data", 32'(bus.m_data), 32'(exp_q[0]));
      chk("last", 32'(bus.m_last), 32'((beats % eff) == eff - 1));
      chk("done_lo_stream", 32'(bus.done), 32'd0);
      case (mode)
        0: rdy = 1'b1;
        1: rdy = pat[cyc % 4];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      idle_inputs();
      if (abort_beat > 0 && beats + 1 == abort_beat) begin
        rdy = 1'b1;
        bus.abort = 1'b1;
      end
      if (poke) begin
        bus.wr_en = 1'b1;
        bus.wr_addr = 4'($urandom_range(0, DEPTH - 1));
        bus.wr_data = 8'($urandom);
        bus.start = 1'b1;
        bus.len = 5'd1;
      end
      bus.m_ready = rdy;
      if (rdy) begin
        void'(exp_q.pop_front());
        beats++;
      end
      cyc++;
      @(negedge clk);
    end
    if (beats < total) chk("timeout_beats", 32'(beats), 32'(total));
    idle_inputs();
    chk("valid_lo_end", 32'(bus.m_valid), 32'd0);
    chk("busy_lo_end", 32'(bus.busy), 32'd0);
    chk("last_lo_end", 32'(bus.m_last), 32'd0);
    chk("done_end", 32'(bus.done), 32'(exp_done));
    chk("state_idle_end", 32'(bus.dbg_state), 32'(IDLE));
    if (exp_done) begin
      @(negedge clk);
      chk("done_one_cycle", 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    idle_inputs();
    #1 reset = 1'b1;
    #20;
    chk("rst_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_data", 32'(bus.m_data), 32'd0);
    chk("rst_last", 32'(bus.m_last), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < MSG_HELLO_LEN; i++) write_buf(i, hello_char(i));
    stream_run(13, 1'b0, 0, 0, 1'b0);
    stream_run(13, 1'b0, 1, 0, 1'b0);

    write_buf(0, 8'h61);
    write_buf(1, 8'h62);
    write_buf(2, 8'h63);
    stream_run(3, 1'b1, 0, 7, 1'b0);

    stream_run(0, 1'b0, 0, 0, 1'b0);

    for (int i = 0; i < DEPTH; i++) write_buf(i, 8'($urandom));
    stream_run(20, 1'b0, 2, 0, 1'b0);
    stream_run(16, 1'b0, 2, 0, 1'b1);
    stream_run(16, 1'b0, 0, 0, 1'b0);

    // Reset in the middle of a stream.
    @(negedge clk);
    idle_inputs();
    bus.start = 1'b1;
    bus.len = 5'd16;
    @(negedge clk);
    idle_inputs();
    bus.m_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_valid", 32'(bus.m_valid), 32'd0);
    chk("midrst_data", 32'(bus.m_data), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_last", 32'(bus.m_last), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("postrst_done", 32'(bus.done), 32'd0);
    chk("postrst_state", 32'(bus.dbg_state), 32'(IDLE));
    stream_run(5, 1'b0, 0, 0, 1'b0);

    // Abort coincident with the final handshake of a single-shot pass.
    stream_run(5, 1'b0, 2, 5, 1'b0);
    stream_run(4, 1'b0, 0, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      int l;
      bit rp;
      int ab;
      l = $urandom_range(0, 20);
      rp = 1'($urandom_range(0, 1));
      if (rp) ab = $urandom_range(1, 30);
      else ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 20) : 0;
      stream_run(l, rp, 2, ab, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
